// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: load-use detection, multi-cycle divider scoreboard,
// branch flush priority and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic [4:0]  ID_rd,
  input  logic        ID_RegW,
  input  logic        ID_div,
  input  logic [4:0]  ID_EX_rd,
  input  logic        ID_EX_MemR,
  input  logic        br_taken,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        div_busy,
  output logic        div_done,
  output logic [4:0]  div_rd_q,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [5:0]  cnt_r, cnt_s;
  logic [4:0]  rd_s;
  logic        load_use_s, div_hz_s, stall_s, issue_s;

  // Hazard detection; x0 is excluded so it never matches anything.
  always_comb begin
    load_use_s = ID_EX_MemR && (ID_EX_rd != 5'd0) &&
                 ((use_rs1 && (ID_EX_rd == rs1)) || (use_rs2 && (ID_EX_rd == rs2)));
    div_hz_s   = 1'b0;
    if (state_r != IDLE) begin
      div_hz_s = ((div_rd_q != 5'd0) &&
                  ((use_rs1 && (rs1 == div_rd_q)) ||
                   (use_rs2 && (rs2 == div_rd_q)) ||
                   (ID_RegW && (ID_rd == div_rd_q)))) || ID_div;
    end else begin
      div_hz_s = 1'b0;
    end
    // A taken branch flushes the dependent instruction, so it never stalls.
    stall_s = !br_taken && (load_use_s || div_hz_s);
    issue_s = ID_div && !stall_s && !br_taken;
  end

  // Divider FSM next-state, countdown and destination capture.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rd_s    = div_rd_q;
    case (state_r)
      IDLE: begin
        if (issue_s) begin
          state_s = BUSY;
          cnt_s   = 6'(DIV_LAT - 1);
          rd_s    = ID_RegW ? ID_rd : 5'd0;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r <= 6'd1) begin
          state_s = DONE;
        end else begin
          cnt_s = cnt_r - 6'd1;
        end
      end
      DONE: begin
        if (issue_s) begin
          state_s = BUSY;
          cnt_s   = 6'(DIV_LAT - 1);
          rd_s    = ID_RegW ? ID_rd : 5'd0;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 6'd0;
      end
    endcase
  end

  // State, counter and destination registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= 6'd0;
      div_rd_q <= 5'd0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      div_rd_q <= rd_s;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (stall_s && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  assign PC_write    = !stall_s;
  assign IF_ID_write = !stall_s;
  assign IF_ID_flush = br_taken;
  assign ID_EX_flush = br_taken || stall_s;
  assign div_busy    = (state_r != IDLE);
  assign div_done    = (state_r == DONE);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven and sequence checks for hazard_scoreboard with DIV_LAT=8.
module tb_hazard_scoreboard;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, ID_rd = 5'd0, ID_EX_rd = 5'd0;
  logic        use_rs1 = 1'b0, use_rs2 = 1'b0, ID_RegW = 1'b0, ID_div = 1'b0;
  logic        ID_EX_MemR = 1'b0, br_taken = 1'b0;
  logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, div_busy, div_done;
  logic [4:0]  div_rd_q;
  logic [31:0] stall_cnt;

  hazard_scoreboard #(.DIV_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .ID_rd(ID_rd), .ID_RegW(ID_RegW), .ID_div(ID_div), .ID_EX_rd(ID_EX_rd),
    .ID_EX_MemR(ID_EX_MemR), .br_taken(br_taken), .PC_write(PC_write),
    .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .div_busy(div_busy), .div_done(div_done), .div_rd_q(div_rd_q), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2, id_rd, ex_rd;
    logic u1, u2, regw, div, memr, br;
    logic pcw, ifl, exf, busy, done;
    logic [31:0] ecnt;
  } vec_t;

  vec_t q[$];
  vec_t tbl[12];
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt = 32'd0;

  function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2, input logic u1,
                              input logic u2, input logic [4:0] rd, input logic regw,
                              input logic dv, input logic [4:0] exrd, input logic memr,
                              input logic br, input logic pcw, input logic ifl,
                              input logic exf, input logic busy, input logic done);
    vec_t v;
    v.rs1 = a1; v.rs2 = a2; v.u1 = u1; v.u2 = u2; v.id_rd = rd; v.regw = regw;
    v.div = dv; v.ex_rd = exrd; v.memr = memr; v.br = br;
    v.pcw = pcw; v.ifl = ifl; v.exf = exf; v.busy = busy; v.done = done;
    v.ecnt = 32'd0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rs1 = v.rs1; rs2 = v.rs2; use_rs1 = v.u1; use_rs2 = v.u2; ID_rd = v.id_rd;
    ID_RegW = v.regw; ID_div = v.div; ID_EX_rd = v.ex_rd; ID_EX_MemR = v.memr;
    br_taken = v.br;
  endtask

  // Drive one cycle, queue its expectation, compare at the falling edge.
  task automatic run_vec(input vec_t v);
    vec_t e;
    drive(v);
    v.ecnt = exp_cnt;
    q.push_back(v);
    @(negedge clk);
    e = q.pop_front();
    chk("pc_write", 32'(PC_write), 32'(e.pcw));
    chk("if_id_write", 32'(IF_ID_write), 32'(e.pcw));
    chk("if_id_flush", 32'(IF_ID_flush), 32'(e.ifl));
    chk("id_ex_flush", 32'(ID_EX_flush), 32'(e.exf));
    chk("div_busy", 32'(div_busy), 32'(e.busy));
    chk("div_done", 32'(div_done), 32'(e.done));
    chk("stall_cnt", stall_cnt, e.ecnt);
    if (!e.pcw) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  // Idle ID stream while a divide issued at the previous edge completes.
  task automatic drain_div(input int from_cycle);
    for (int c = from_cycle; c <= LAT - 2; c++)
      run_vec(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    run_vec(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    run_vec(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    //            rs1    rs2    u1    u2    id_rd  regw  div   ex_rd  memr  br    pcw   ifl   exf   busy  done
    tbl[0]  = mk(5'd5,  5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(5'd5,  5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(5'd5,  5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(5'd0,  5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(5'd5,  5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(5'd1,  5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(5'd1,  5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(5'd5,  5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(5'd2,  5'd3, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(5'd0,  5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(5'd31, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(5'd4,  5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state, checked before any clock edge.
    #2;
    chk("rst_pc_write", 32'(PC_write), 32'd1);
    chk("rst_if_id_write", 32'(IF_ID_write), 32'd1);
    chk("rst_if_id_flush", 32'(IF_ID_flush), 32'd0);
    chk("rst_id_ex_flush", 32'(ID_EX_flush), 32'd0);
    chk("rst_div_busy", 32'(div_busy), 32'd0);
    chk("rst_div_done", 32'(div_done), 32'd0);
    chk("rst_div_rd_q", 32'(div_rd_q), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) run_vec(tbl[i]);

    // Divide RAW: stall cycles 1..7, done in cycle 7, released in cycle 8.
    run_vec(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("raw_div_rd_q", 32'(div_rd_q), 32'd7);
    run_vec(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int c = 1; c <= LAT - 2; c++)
      run_vec(mk(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    run_vec(mk(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    run_vec(mk(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    // Back-to-back divides: the second waits until IDLE, then issues.
    run_vec(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("b2b_first_rd_q", 32'(div_rd_q), 32'd3);
    for (int c = 0; c <= LAT - 2; c++)
      run_vec(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    run_vec(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    run_vec(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("b2b_second_rd_q", 32'(div_rd_q), 32'd9);
    drain_div(0);

    // Branch priority over load-use and divide hazards; divide still completes.
    run_vec(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    run_vec(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    run_vec(mk(5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    run_vec(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    drain_div(3);

    // x0 destination in flight never stalls readers of x0.
    run_vec(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    chk("x0_div_rd_q", 32'(div_rd_q), 32'd0);
    run_vec(mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    drain_div(1);

    // Asynchronous reset at counter 3 abandons the divide.
    run_vec(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int c = 0; c <= 3; c++)
      run_vec(mk(5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_div_busy", 32'(div_busy), 32'd0);
    chk("arst_stall_cnt", stall_cnt, 32'd0);
    chk("arst_div_rd_q", 32'(div_rd_q), 32'd0);
    chk("arst_pc_write", 32'(PC_write), 32'd1);
    exp_cnt = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < LAT + 2; c++)
      run_vec(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter DIV_LAT, default 8, divider latency in cycles from issue to result-valid (legal range 2..32).
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rs1, rs2  input  5 each  source register indices of the instruction in ID.
REQ-005 use_rs1, use_rs2  input  1 each  ID instruction actually reads rs1 / rs2 (use_rs2 low for immediate forms).
REQ-006 ID_rd  input  5  destination index of the ID instruction.
REQ-007 ID_RegW  input  1  ID instruction writes ID_rd.
REQ-008 ID_div  input  1  ID instruction is a divide/remainder op.
REQ-009 ID_EX_rd  input  5  destination index of the instruction in EX.
REQ-010 ID_EX_MemR  input  1  EX instruction is a load.
REQ-011 br_taken  input  1  EX resolved a taken branch/jump this cycle.
REQ-012 PC_write  output  1  high = PC may advance.
REQ-013 IF_ID_write  output  1  high = IF/ID register may load.
REQ-014 IF_ID_flush  output  1  high = IF/ID register cleared to NOP next edge.
REQ-015 ID_EX_flush  output  1  high = ID/EX register loads a bubble next edge.
REQ-016 div_busy  output  1  divider occupied.
REQ-017 div_done  output  1  one-cycle pulse: divider result written to div_rd_q at this edge.
REQ-018 div_rd_q  output  5  destination register of the in-flight divide.
REQ-019 stall_cnt  output  32  count of cycles in which stall was asserted.

Function
REQ-020 Register x0 never causes a hazard: any comparison with index 0 is false.
REQ-021 load_use = ID_EX_MemR & ID_EX_rd!=0 & ((use_rs1 & ID_EX_rd==rs1) | (use_rs2 & ID_EX_rd==rs2)).
REQ-022 FSM states IDLE, BUSY, DONE; encoding free.
REQ-023 div_hz (only in BUSY or DONE) = div_rd_q!=0 & ((use_rs1 & rs1==div_rd_q) | (use_rs2 & rs2==div_rd_q) | (ID_RegW & ID_rd==div_rd_q)) | ID_div.
REQ-024 stall = ~br_taken & (load_use | div_hz); all combinational from current inputs and state.
REQ-025 PC_write = IF_ID_write = ~stall.
REQ-026 IF_ID_flush = br_taken; ID_EX_flush = br_taken | stall.
REQ-027 Issue = ID_div & ~stall & ~br_taken; only legal in IDLE (or DONE, see REQ-030).
REQ-028 IDLE + issue -> BUSY; counter loads DIV_LAT-1; div_rd_q loads ID_rd (0 if ~ID_RegW).
REQ-029 BUSY: counter decrements each cycle; counter==1 -> DONE next edge.
REQ-030 DONE: div_done=1 for exactly this cycle; next state IDLE, or BUSY if a new issue occurs in the same cycle (back-to-back divides stall at least one cycle via REQ-023 until DONE exits, so issue from DONE does not occur; state remains IDLE next).
REQ-031 Issue-to-div_done = DIV_LAT cycles: issue at edge N, div_done high in cycle N+DIV_LAT-1 and low afterwards.
REQ-032 div_busy = (state != IDLE); div_rd_q holds its value until the next issue.
REQ-033 Counter width 6 bits; never wraps (reloaded only on issue, stops at 1).
REQ-034 br_taken does not cancel an in-flight divide (it is older than the branch); a divide in ID during br_taken is not issued.
REQ-035 br_taken and load_use together: flush wins, stall=0, PC_write=1.
REQ-036 stall_cnt increments by 1 on every edge where stall=1; saturates at 0xFFFFFFFF.

Reset
REQ-037 rst=1 immediately forces state IDLE, counter 0, div_rd_q 0, div_done 0, stall_cnt 0, independent of clk.
REQ-038 During and after reset with no hazard inputs: PC_write=1, IF_ID_write=1, both flushes 0, div_busy 0.
REQ-039 rst asserted mid-divide abandons it: no div_done pulse follows deassertion.

Verification
REQ-040 Load-use: ID_EX_MemR=1, ID_EX_rd=5, rs1=5, use_rs1=1 -> stall one cycle: PC_write=0, IF_ID_write=0, ID_EX_flush=1; ID_EX_rd=0 same stimulus -> no stall.
REQ-041 Divide RAW: DIV_LAT=8, issue div rd=7 at edge 0; next ID reads rs2=7 -> stall cycles 1..7, div_done high cycle 7 only, stall released cycle 8, stall_cnt=7.
REQ-042 Back-to-back divide: second ID_div during BUSY -> stalled until state IDLE, then issues; div_rd_q updates to second rd.
REQ-043 Branch priority: br_taken=1 with load_use=1 -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1, stall_cnt unchanged; in-flight divide still completes with div_done.
REQ-044 Async reset at BUSY counter=3 -> div_busy=0 without clock edge; no div_done afterwards; stall_cnt=0.
REQ-045 x0 guard: div rd=0 in flight, ID reads rs1=0 -> no stall.
